// File: rtl/sccb_init_seq.sv
// rtl/sccb_init_seq.sv - camera power-up sequencer and SCCB register-write master
// Releases CSI reset on a timer, then writes every ROM table entry over SCCB.
module sccb_init_seq #(
  parameter int         CLK_DIV     = 125,
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         RST_CYCLES  = 500000,
  parameter int         WAIT_CYCLES = 1000000,
  parameter int         AUTO_START  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        START,
  output logic [7:0]  ROM_ADDR,
  input  logic [15:0] ROM_DATA,
  output logic        SIOC,
  output logic        SIOD_OE,
  output logic        CSI_RST,
  output logic        CSI_PWDN,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  WR_CNT
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RST_HOLD = 4'd1;
  localparam logic [3:0] S_PWR_WAIT = 4'd2;
  localparam logic [3:0] S_FETCH    = 4'd3;
  localparam logic [3:0] S_START_B  = 4'd4;
  localparam logic [3:0] S_BIT      = 4'd5;
  localparam logic [3:0] S_STOP_B   = 4'd6;
  localparam logic [3:0] S_GAP      = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;

  localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [4:0]        LAST_BIT  = 5'd26;

  logic [3:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [4:0]        bit_q, bit_d;
  logic [26:0]       frame_q, frame_d;
  logic              fetch_q, fetch_d;
  logic [7:0]        rom_addr_q, rom_addr_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic              sioc_q, sioc_d;
  logic              siod_oe_q, siod_oe_d;
  logic              csi_rst_q, csi_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        lvl_d;

  logic in_bus;
  logic tick;
  logic bit_end;

  // Line levels {SIOC, SIOD} for a given state and quarter of the current bit.
  function automatic logic [1:0] bus_level(input logic [3:0] st, input logic [1:0] q,
                                           input logic b);
    case (st)
      S_START_B: bus_level = {q != 2'd3, q == 2'd0};
      S_BIT:     bus_level = {(q == 2'd1) || (q == 2'd2), b};
      S_STOP_B:  bus_level = {q != 2'd0, q[1]};
      default:   bus_level = 2'b11;
    endcase
  endfunction

  assign in_bus  = (state_q == S_START_B) || (state_q == S_BIT) ||
                   (state_q == S_STOP_B)  || (state_q == S_GAP);
  assign tick    = in_bus && (tick_q == TICK_LAST);
  assign bit_end = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tick_d     = '0;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    fetch_d    = fetch_q;
    rom_addr_d = rom_addr_q;
    wr_cnt_d   = wr_cnt_q;

    if (in_bus) begin
      tick_d = tick ? '0 : tick_q + TICK_W'(1);
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (START || (AUTO_START != 0)) begin
          state_d    = S_RST_HOLD;
          cnt_d      = '0;
          rom_addr_d = '0;
          wr_cnt_d   = '0;
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_PWR_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        // First clock presents the address; the ROM answers on the second.
        fetch_d = ~fetch_q;
        if (fetch_q) begin
          if (ROM_DATA == 16'hFFFF) begin
            state_d = S_FIN;
          end else begin
            state_d = S_START_B;
            qtr_d   = 2'd0;
            frame_d = {DEV_ADDR, 1'b1, ROM_DATA[15:8], 1'b1, ROM_DATA[7:0], 1'b1};
          end
        end
      end
      S_START_B: begin
        if (bit_end) begin
          state_d = S_BIT;
          bit_d   = '0;
        end
      end
      S_BIT: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = S_STOP_B;
          end else begin
            bit_d   = bit_q + 5'd1;
            frame_d = {frame_q[25:0], 1'b1};
          end
        end
      end
      S_STOP_B: begin
        if (bit_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (bit_end) begin
          wr_cnt_d = wr_cnt_q + 8'd1;
          // The table index saturates at the last slot rather than wrapping.
          if (rom_addr_q == 8'hFF) begin
            state_d = S_FIN;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end
      end
      S_FIN: begin
        if (START) begin
          state_d    = S_RST_HOLD;
          cnt_d      = '0;
          rom_addr_d = '0;
          wr_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are decoded from the next state so they leave flops, glitch-free.
  always_comb begin
    lvl_d     = bus_level(state_d, qtr_d, frame_d[26]);
    sioc_d    = lvl_d[1];
    siod_oe_d = ~lvl_d[0];
    csi_rst_d = (state_d != S_IDLE) && (state_d != S_RST_HOLD);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d    = (state_d == S_FIN);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tick_q     <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      fetch_q    <= 1'b0;
      rom_addr_q <= '0;
      wr_cnt_q   <= '0;
      sioc_q     <= 1'b1;
      siod_oe_q  <= 1'b0;
      csi_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      fetch_q    <= fetch_d;
      rom_addr_q <= rom_addr_d;
      wr_cnt_q   <= wr_cnt_d;
      sioc_q     <= sioc_d;
      siod_oe_q  <= siod_oe_d;
      csi_rst_q  <= csi_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ROM_ADDR = rom_addr_q;
  assign SIOC     = sioc_q;
  assign SIOD_OE  = siod_oe_q;
  assign CSI_RST  = csi_rst_q;
  assign CSI_PWDN = 1'b0;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign WR_CNT   = wr_cnt_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb/tb_sccb_init_seq.sv - self-checking bench for sccb_init_seq
// Expected pin timelines are generated from the bus rules and compared every clock.
`timescale 1ns/1ps
module tb_sccb_init_seq;

  localparam int CLK_DIV  = 4;
  localparam int RST_CYC  = 8;
  localparam int WAIT_CYC = 16;
  localparam logic [21:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst_a, start_a, sioc_a, oe_a, csirst_a, pwdn_a, busy_a, done_a;
  logic [7:0]  addr_a, wr_a;
  logic [15:0] data_a;
  logic        nrst_b, start_b, sioc_b, oe_b, csirst_b, pwdn_b, busy_b, done_b;
  logic [7:0]  addr_b, wr_b;
  logic [15:0] data_b;

  logic [15:0] rom_mem [256];

  always @(posedge clk) begin
    data_a <= rom_mem[addr_a];
    data_b <= rom_mem[addr_b];
  end

  sccb_init_seq #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h42), .RST_CYCLES(RST_CYC),
                  .WAIT_CYCLES(WAIT_CYC), .AUTO_START(1)) dut_a (
    .CLK(clk), .nRST(nrst_a), .START(start_a), .ROM_ADDR(addr_a), .ROM_DATA(data_a),
    .SIOC(sioc_a), .SIOD_OE(oe_a), .CSI_RST(csirst_a), .CSI_PWDN(pwdn_a),
    .BUSY(busy_a), .DONE(done_a), .WR_CNT(wr_a));

  // Fast-bus copy so a full 256-entry table fits in a short run.
  sccb_init_seq #(.CLK_DIV(1), .DEV_ADDR(8'h42), .RST_CYCLES(RST_CYC),
                  .WAIT_CYCLES(WAIT_CYC), .AUTO_START(1)) dut_b (
    .CLK(clk), .nRST(nrst_b), .START(start_b), .ROM_ADDR(addr_b), .ROM_DATA(data_b),
    .SIOC(sioc_b), .SIOD_OE(oe_b), .CSI_RST(csirst_b), .CSI_PWDN(pwdn_b),
    .BUSY(busy_b), .DONE(done_b), .WR_CNT(wr_b));

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [21:0] exp_q[$];
  logic [21:0] obs_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] observe(input int sel);
    if (sel == 0) return {sioc_a, oe_a, csirst_a, pwdn_a, busy_a, done_a, addr_a, wr_a};
    return {sioc_b, oe_b, csirst_b, pwdn_b, busy_b, done_b, addr_b, wr_b};
  endfunction

  task automatic push_n(input int n, input bit sioc, input bit siod, input bit rst,
                        input bit busy, input bit done, input logic [7:0] a,
                        input logic [7:0] w);
    repeat (n) exp_q.push_back({sioc, ~siod, rst, 1'b0, busy, done, a, w});
  endtask

  // Timeline: reset hold, power wait, then per entry 2 fetch clocks and 30 bit
  // times of 4 quarters each (start, 27 data/ack bits, stop, idle gap).
  task automatic build_model(input int clk_div);
    logic [7:0]  a;
    logic [7:0]  w;
    logic [15:0] e;
    logic [26:0] bits;
    logic [1:0]  qs[$];
    exp_q.delete();
    push_n(RST_CYC, 1, 1, 0, 1, 0, 8'h00, 8'h00);
    push_n(WAIT_CYC, 1, 1, 1, 1, 0, 8'h00, 8'h00);
    a = 8'h00;
    w = 8'h00;
    for (int n = 0; n < 257; n++) begin
      push_n(2, 1, 1, 1, 1, 0, a, w);
      e = rom_mem[a];
      if (e == 16'hFFFF) break;
      bits = {8'h42, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
      qs.delete();
      qs.push_back(2'b11); qs.push_back(2'b10); qs.push_back(2'b10); qs.push_back(2'b00);
      for (int i = 26; i >= 0; i--) begin
        qs.push_back({1'b0, bits[i]}); qs.push_back({1'b1, bits[i]});
        qs.push_back({1'b1, bits[i]}); qs.push_back({1'b0, bits[i]});
      end
      qs.push_back(2'b00); qs.push_back(2'b10); qs.push_back(2'b11); qs.push_back(2'b11);
      repeat (4) qs.push_back(2'b11);
      foreach (qs[j]) push_n(clk_div, qs[j][1], qs[j][0], 1, 1, 0, a, w);
      w = w + 8'd1;
      if (a == 8'hFF) break;
      a = a + 8'd1;
    end
    push_n(8, 1, 1, 1, 0, 1, a, w);
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic run_check(input int sel, input int abort_at, input bit poke,
                           output bit aborted);
    logic [21:0] cur;
    int f0;
    aborted = 1'b0;
    obs_log.delete();
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      cur = observe(sel);
      obs_log.push_back(cur);
      f0 = n_fail;
      check($sformatf("wave%0d[%0d]", sel, k), 32'(cur), 32'(exp_q[k]));
      if (n_fail != f0) break;
      if (k == abort_at) begin
        if (sel == 0) nrst_a = 1'b0; else nrst_b = 1'b0;
        #1;
        check("abort_outputs", 32'(observe(sel)), 32'(RESET_VEC));
        aborted = 1'b1;
        break;
      end
      if (poke && exp_q[k][17] && ($urandom_range(0, 5) == 0)) set_start(sel, 1'b1);
    end
  endtask

  int          r_idx, lowcnt, nb, s0, s1, sioc_low, done_idx;
  int          starts[$];
  logic [26:0] dec;
  logic [2:0]  ack_oe;
  bit          stop_seen, ab;
  logic [15:0] e;
  int          tlen;

  initial begin
    nrst_a = 1'b0; nrst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    foreach (rom_mem[i]) rom_mem[i] = 16'hFFFF;
    rom_mem[0] = 16'h1280;
    rom_mem[1] = 16'h1101;
    repeat (3) @(negedge clk);
    check("reset_a", 32'(observe(0)), 32'(RESET_VEC));
    check("reset_b", 32'(observe(1)), 32'(RESET_VEC));

    // Two-entry table from reset release.
    build_model(CLK_DIV);
    nrst_a = 1'b1;
    run_check(0, -1, 1'b0, ab);
    check("final_done", 32'(done_a), 32'd1);
    check("final_wr_cnt", 32'(wr_a), 32'd2);
    check("final_rom_addr", 32'(addr_a), 32'd2);

    lowcnt = 0; r_idx = -1;
    starts.delete();
    for (int k = 0; k < obs_log.size(); k++) begin
      if (obs_log[k][19] && r_idx < 0) r_idx = k;
      if (r_idx < 0 && obs_log[k][17] && !obs_log[k][19]) lowcnt++;
      if (k > 0 && obs_log[k][21] && obs_log[k-1][21] && obs_log[k][20] && !obs_log[k-1][20])
        starts.push_back(k);
    end
    s0 = (starts.size() > 0) ? starts[0] : -1000;
    s1 = (starts.size() > 1) ? starts[1] : -1000;
    check("csi_rst_low_clocks", 32'(lowcnt), 32'(RST_CYC));
    check("start_cond_count", 32'(starts.size()), 32'd2);
    // Start condition falls one quarter into START_B, after the wait and 2 fetch clocks.
    check("first_sda_fall", 32'(s0 - r_idx), 32'(WAIT_CYC + 2 + CLK_DIV));
    check("write_spacing", 32'(s1 - s0), 32'(120 * CLK_DIV + 2));

    dec = '0; nb = 0; ack_oe = '0; stop_seen = 1'b0;
    for (int k = (s0 > 0 ? s0 + 1 : 1); k < obs_log.size() && k < s0 + 120 * CLK_DIV; k++) begin
      if (obs_log[k][21] && !obs_log[k-1][21]) begin
        if (nb < 27) dec = {dec[25:0], ~obs_log[k][20]};
        if (nb == 8 || nb == 17 || nb == 26) ack_oe = {ack_oe[1:0], obs_log[k][20]};
        nb++;
      end
      if (nb >= 28 && obs_log[k][21] && obs_log[k-1][21] && obs_log[k-1][20] && !obs_log[k][20])
        stop_seen = 1'b1;
    end
    check("dec_dev_addr", 32'(dec[26:19]), 32'h42);
    check("dec_reg_addr", 32'(dec[17:10]), 32'h12);
    check("dec_value", 32'(dec[8:1]), 32'h80);
    check("ack_bits_released", 32'(ack_oe), 32'd0);
    check("sioc_rise_count", 32'(nb), 32'd28);
    check("stop_cond_seen", 32'(stop_seen), 32'd1);

    // Empty table restarted from DONE.
    rom_mem[0] = 16'hFFFF;
    build_model(CLK_DIV);
    @(negedge clk); start_a = 1'b1;
    run_check(0, -1, 1'b0, ab);
    sioc_low = 0; done_idx = -1;
    foreach (obs_log[k]) begin
      if (!obs_log[k][21]) sioc_low++;
      if (obs_log[k][16] && done_idx < 0) done_idx = k;
    end
    check("empty_sioc_low", 32'(sioc_low), 32'd0);
    check("empty_done_at", 32'(done_idx), 32'(RST_CYC + WAIT_CYC + 2));
    check("empty_wr_cnt", 32'(wr_a), 32'd0);

    // START pulses while busy must not disturb the waveform.
    rom_mem[0] = 16'h1280;
    build_model(CLK_DIV);
    @(negedge clk); start_a = 1'b1;
    run_check(0, -1, 1'b1, ab);

    // Reset during bit 10 of the first write, then rerun from reset release.
    @(negedge clk); start_a = 1'b1;
    run_check(0, RST_CYC + WAIT_CYC + 2 + 4 * CLK_DIV * 10, 1'b0, ab);
    check("abort_taken", 32'(ab), 32'd1);
    repeat (2) @(negedge clk);
    check("abort_held", 32'(observe(0)), 32'(RESET_VEC));
    nrst_a = 1'b1;
    run_check(0, -1, 1'b1, ab);
    check("rerun_wr_cnt", 32'(wr_a), 32'd2);

    // Random tables, random START noise while busy.
    for (int t = 0; t < 5; t++) begin
      tlen = $urandom_range(0, 4);
      for (int i = 0; i < tlen; i++) begin
        e = 16'($urandom);
        if (e == 16'hFFFF) e = 16'h0000;
        rom_mem[i] = e;
      end
      rom_mem[tlen] = 16'hFFFF;
      build_model(CLK_DIV);
      @(negedge clk); start_a = 1'b1;
      run_check(0, -1, 1'b1, ab);
      check($sformatf("rand%0d_wr_cnt", t), 32'(wr_a), 32'(tlen));
    end

    // Full 256-entry table: count wraps, address saturates.
    foreach (rom_mem[i]) begin
      e = 16'($urandom);
      if (e == 16'hFFFF) e = 16'h1234;
      rom_mem[i] = e;
    end
    build_model(1);
    @(negedge clk); nrst_b = 1'b1;
    run_check(1, -1, 1'b0, ab);
    check("full_done", 32'(done_b), 32'd1);
    check("full_wr_cnt", 32'(wr_b), 32'd0);
    check("full_rom_addr", 32'(addr_b), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
